// File: rtl/eth_pcs_rx_block_sync_pkg.sv
// eth_pcs_params: shared sync-header constants, default thresholds and lock FSM states.
package eth_pcs_params;
  localparam int W_SYNC = 2;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;
  localparam int SH_VAL_TH_DEF = 64;
  localparam int SH_INVAL_TH_DEF = 16;
  localparam int SLIP_WAIT_DEF = 4;
  localparam int BER_WINDOW_DEF = 19531;
  localparam int BER_TH_DEF = 16;
  typedef enum logic [1:0] {LOCK_INIT, RESET_CNT, TEST_SH, SLIP_WAIT_ST} sync_state_t;
  function automatic logic sh_valid(input logic [W_SYNC-1:0] h);
    return h == SYNC_DATA || h == SYNC_CTRL;
  endfunction
endpackage

// File: rtl/eth_pcs_rx_block_sync_ber_mon.sv
// eth_pcs_ber_mon: windowed invalid-header counter raising hi_ber; forced high while unlocked.
module eth_pcs_ber_mon
  import eth_pcs_params::*;
#(
  parameter int BER_WINDOW = BER_WINDOW_DEF,
  parameter int BER_TH = BER_TH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hdr_bad,
  input  logic       block_lock,
  output logic       hi_ber,
  output logic [5:0] ber_cnt
);
  localparam int TW = $clog2(BER_WINDOW);
  localparam logic [5:0] TH = 6'(BER_TH);
  logic [TW-1:0] timer;
  logic expire, over;
  assign expire = timer == TW'(BER_WINDOW - 1);
  assign over = ber_cnt >= TH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer <= '0;
      ber_cnt <= '0;
      hi_ber <= 1'b0;
    end else if (!block_lock) begin
      timer <= '0;
      ber_cnt <= '0;
      hi_ber <= 1'b1;
    end else begin
      timer <= expire ? '0 : timer + 1'b1;
      ber_cnt <= expire ? 6'(hdr_bad) : ber_cnt + 6'(hdr_bad && ber_cnt != 6'd63);
      hi_ber <= expire ? over : hi_ber | over;
    end
endmodule

// File: rtl/eth_pcs_rx_block_sync.sv
// eth_pcs_rx_block_sync: 10GBASE-R block lock FSM with gearbox slip control.
// Define ETH_PCS_HIBER_EN to build the high-BER monitor; otherwise o_hi_ber/o_ber_cnt are 0.
module eth_pcs_rx_block_sync
  import eth_pcs_params::*;
#(
  parameter int SH_VAL_TH = SH_VAL_TH_DEF,
  parameter int SH_INVAL_TH = SH_INVAL_TH_DEF,
  parameter int SLIP_WAIT = SLIP_WAIT_DEF,
  parameter int BER_WINDOW = BER_WINDOW_DEF,
  parameter int BER_TH = BER_TH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hdr_vld,
  input  logic [W_SYNC-1:0] i_hdr,
  output logic              o_slip,
  output logic              o_block_lock,
  output logic              o_hi_ber,
  output logic [5:0]        o_ber_cnt
);
  localparam int CW = $clog2(SH_VAL_TH + 1);
  localparam int IW = $clog2(SH_INVAL_TH + 1);
  if (SLIP_WAIT < 0 || SLIP_WAIT > 255 || BER_WINDOW < 2 || BER_TH < 1 || BER_TH > 63) begin : g_param_chk
    $error("eth_pcs_rx_block_sync: parameter out of range");
  end
  sync_state_t state, state_nx;
  logic [CW-1:0] sh_cnt, cnt_base, cnt_inc;
  logic [IW-1:0] inv_cnt, inv_base, inv_inc;
  logic [7:0] wait_cnt;
  logic bad, testing, slip_hit, win_end, wait_done, slip_nx, lock_nx;
  // A strobe in RESET_CNT counts from zero, so RESET_CNT and TEST_SH share the header evaluation.
  assign bad = i_hdr_vld && !sh_valid(i_hdr);
  assign testing = state == RESET_CNT || state == TEST_SH;
  assign cnt_base = state == RESET_CNT ? '0 : sh_cnt;
  assign inv_base = state == RESET_CNT ? '0 : inv_cnt;
  assign cnt_inc = cnt_base + CW'(1);
  assign inv_inc = inv_base + IW'(bad);
  assign slip_hit = bad && (!o_block_lock || inv_inc == IW'(SH_INVAL_TH));
  assign win_end = cnt_inc == CW'(SH_VAL_TH);
  assign wait_done = SLIP_WAIT == 0 || (i_hdr_vld && wait_cnt == 8'(SLIP_WAIT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LOCK_INIT;
      sh_cnt <= '0;
      inv_cnt <= '0;
      wait_cnt <= '0;
      o_slip <= 1'b0;
      o_block_lock <= 1'b0;
    end else begin
      state <= state_nx;
      sh_cnt <= testing ? (i_hdr_vld ? cnt_inc : cnt_base) : sh_cnt;
      inv_cnt <= testing ? (i_hdr_vld ? inv_inc : inv_base) : inv_cnt;
      wait_cnt <= state == SLIP_WAIT_ST ? wait_cnt + 8'(i_hdr_vld) : '0;
      o_slip <= slip_nx;
      o_block_lock <= lock_nx;
    end
  always_comb begin
    state_nx = state;
    case (state)
      LOCK_INIT:          state_nx = RESET_CNT;
      RESET_CNT, TEST_SH: state_nx = !i_hdr_vld ? TEST_SH : slip_hit ? SLIP_WAIT_ST : win_end ? RESET_CNT : TEST_SH;
      SLIP_WAIT_ST:       state_nx = wait_done ? RESET_CNT : SLIP_WAIT_ST;
      default:            state_nx = LOCK_INIT;
    endcase
  end
  // Slip takes priority over the window boundary on the same header.
  always_comb begin
    slip_nx = testing && slip_hit;
    lock_nx = state == LOCK_INIT ? 1'b0 :
              !(testing && i_hdr_vld) ? o_block_lock :
              slip_hit ? 1'b0 :
              win_end && inv_inc == '0 ? 1'b1 : o_block_lock;
  end
`ifdef ETH_PCS_HIBER_EN
  eth_pcs_ber_mon #(.BER_WINDOW(BER_WINDOW), .BER_TH(BER_TH)) u_ber_mon (
    .clk(clk),
    .rst_n(rst_n),
    .hdr_bad(bad),
    .block_lock(o_block_lock),
    .hi_ber(o_hi_ber),
    .ber_cnt(o_ber_cnt)
  );
`else
  assign o_hi_ber = 1'b0;
  assign o_ber_cnt = '0;
`endif
endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// tb_eth_pcs_rx_block_sync: directed stimulus checked every cycle against a header-counting model.
module tb_eth_pcs_rx_block_sync;
  localparam int VAL = 64, INV = 16, SW = 4, BW = 300, BT = 16;
  localparam bit HB_EN =
`ifdef ETH_PCS_HIBER_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, vld = 1'b0;
  logic [1:0] hdr = 2'b01;
  logic o_slip, o_block_lock, o_hi_ber;
  logic [5:0] o_ber_cnt;
  int errors = 0, checks = 0, slips = 0, snap;
  bit m_lock = 0, m_slip = 0, m_hb = 0;
  int m_n = 0, m_nb = 0, m_skip = 0, m_dead = 1, m_t = 0, m_bc = 0;

  eth_pcs_rx_block_sync #(.SH_VAL_TH(VAL), .SH_INVAL_TH(INV), .SLIP_WAIT(SW), .BER_WINDOW(BW), .BER_TH(BT)) dut (
    .clk(clk), .rst_n(rst_n), .i_hdr_vld(vld), .i_hdr(hdr),
    .o_slip(o_slip), .o_block_lock(o_block_lock), .o_hi_ber(o_hi_ber), .o_ber_cnt(o_ber_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count strobes in 64-header windows; after a slip, skip SW strobes; cycles after reset are dead.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_lock = 0; m_slip = 0; m_hb = 0; m_bc = 0; m_t = 0;
      m_n = 0; m_nb = 0; m_skip = 0; m_dead = 1;
    end else begin : step
      bit bad;
      bad = vld && (hdr == 2'b00 || hdr == 2'b11);
      if (!m_lock) begin m_t = 0; m_bc = 0; m_hb = 1; end
      else if (m_t == BW - 1) begin m_hb = m_bc >= BT; m_bc = bad ? 1 : 0; m_t = 0; end
      else begin
        if (m_bc >= BT) m_hb = 1;
        if (bad && m_bc < 63) m_bc++;
        m_t++;
      end
      m_slip = 0;
      if (m_dead > 0) m_dead--;
      else if (m_skip > 0) begin if (vld) m_skip--; end
      else if (vld) begin
        m_n++;
        if (bad) m_nb++;
        if (bad && (!m_lock || m_nb == INV)) begin
          m_lock = 0; m_slip = 1; m_n = 0; m_nb = 0; m_skip = SW; m_dead = (SW == 0) ? 1 : 0;
        end else if (m_n == VAL) begin
          if (m_nb == 0) m_lock = 1;
          m_n = 0; m_nb = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("slip", o_slip, m_slip);
    chk("lock", o_block_lock, m_lock);
    chk("hi_ber", o_hi_ber, HB_EN ? m_hb : 1'b0);
    chk("ber_cnt", o_ber_cnt, HB_EN ? m_bc : 0);
    if (o_slip === 1'b1) slips++;
  end

  task automatic put(logic v, logic [1:0] h);
    @(negedge clk);
    vld = v;
    hdr = h;
  endtask

  task automatic win(int total, int nbad);
    for (int i = 0; i < total; i++)
      put(1'b1, (i % 64) < nbad ? (i % 2 ? 2'b11 : 2'b00) : (i % 2 ? 2'b10 : 2'b01));
  endtask

  task automatic chk_zero(string name);
    chk({name, "_slip"}, o_slip, 0);
    chk({name, "_lock"}, o_block_lock, 0);
    chk({name, "_hiber"}, o_hi_ber, 0);
    chk({name, "_bercnt"}, o_ber_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hiber_first_clk", o_hi_ber, HB_EN);
    // Lock with idle gaps carrying a bad header that must be ignored.
    for (int k = 0; k < 64; k++) begin
      if (k % 8 == 7) put(1'b0, 2'b00);
      put(1'b1, k % 2 ? 2'b10 : 2'b01);
    end
    chk("no_lock_at_63", o_block_lock, 0);
    put(1'b0, 2'b00);
    chk("lock_at_64", o_block_lock, 1);
    chk("no_slip_locking", slips, 0);
    win(320, 0);
    put(1'b0, 2'b00);
    chk("hiber_clear_clean", o_hi_ber, 0);
    win(128, 8);
    put(1'b0, 2'b00);
    chk("hiber_set", o_hi_ber, HB_EN);
    chk("lock_held_ber", o_block_lock, 1);
    win(704, 0);
    put(1'b0, 2'b00);
    chk("hiber_clear_after", o_hi_ber, 0);
    chk("bercnt_clear_after", o_ber_cnt, 0);
    snap = slips;
    win(64, 15);
    put(1'b0, 2'b00);
    chk("lock_15_bad", o_block_lock, 1);
    chk("no_slip_15_bad", slips, snap);
    win(16, 16);
    put(1'b0, 2'b00);
    chk("slip_16_bad", o_slip, 1);
    chk("unlock_16_bad", o_block_lock, 0);
    win(67, 0);
    put(1'b1, 2'b01);
    chk("relock_not_yet", o_block_lock, 0);
    put(1'b0, 2'b00);
    chk("relock", o_block_lock, 1);
    for (int i = 0; i < 64; i++) put(1'b1, i >= 48 ? (i % 2 ? 2'b11 : 2'b00) : (i % 2 ? 2'b10 : 2'b01));
    put(1'b0, 2'b00);
    chk("slip_on_64th", o_slip, 1);
    chk("unlock_on_64th", o_block_lock, 0);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_in_slip_wait");
    @(negedge clk);
    rst_n = 1'b1;
    put(1'b1, 2'b00);
    chk("hiber_after_rst", o_hi_ber, HB_EN);
    put(1'b0, 2'b00);
    chk("slip_first_bad", o_slip, 1);
    snap = slips;
    repeat (4) put(1'b1, 2'b00);
    put(1'b1, 2'b00);
    chk("no_slip_in_wait", slips, snap);
    put(1'b0, 2'b00);
    chk("slip_after_wait", o_slip, 1);
    win(4, 0);
    win(64, 0);
    put(1'b0, 2'b00);
    chk("lock_after_slips", o_block_lock, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_locked");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) put(1'b0, 2'b00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
